// File: rtl/game_pkg.sv
// ============================================================================
// Module : game_pkg
// Brief  : Shared choice encodings, capture FSM states and legality helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package game_pkg;

  localparam logic [2:0] CAT     = 3'b001;
  localparam logic [2:0] DOG     = 3'b010;
  localparam logic [2:0] CHICKEN = 3'b100;

  typedef enum logic [1:0] {
    S_P1  = 2'd0,
    S_P2  = 2'd1,
    S_OUT = 2'd2
  } capture_state_t;

  // Zero and multi-hot patterns are both rejected.
  function automatic logic is_one_hot(input logic [2:0] v);
    return (v != 3'b000) && ((v & (v - 3'b001)) == 3'b000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module : key_debounce
// Brief  : Two-flop synchronizer, debounce counter and press (1->0) detector
//          for an active-low pushbutton; emits a one-cycle commit pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic commit
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;

  // Everything resets to the released level so a reset never fakes a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync    <= 2'b11;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
      r_cnt     <= '0;
    end else begin
      r_sync    <= {r_sync[0], key_n};
      r_level_d <= r_level;
      if (r_sync[1] != r_level) begin
        if (r_cnt == C_CNT_LAST) begin
          r_level <= r_sync[1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign commit = r_level_d & ~r_level;

endmodule

`default_nettype wire

// File: rtl/choice_capture.sv
// ============================================================================
// Module : choice_capture
// Brief  : Captures player 1 / player 2 choices on debounced commit presses
//          and hands the pair downstream with a valid/ready handshake.
//          Optional player-2 timeout enabled by macro CAPTURE_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module choice_capture
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 500000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw_choice,
  input  logic       key_commit_n,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] p1_choice,
  output logic [2:0] p2_choice,
  output logic       waiting_p1,
  output logic       waiting_p2,
  output logic       invalid_pulse,
  output logic       timeout_pulse
);

  capture_state_t r_state;
  capture_state_t w_state_next;

  logic       w_commit;
  logic       w_legal;
  logic       w_latch_p1;
  logic       w_latch_p2;
  logic       w_invalid;
  logic       w_timeout;
  logic       w_timeout_hit;
  logic [2:0] r_p1;
  logic [2:0] r_p2;
  logic       r_invalid;
  logic       r_timeout;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .key_n (key_commit_n),
    .commit(w_commit)
  );

  assign w_legal = is_one_hot(sw_choice);

`ifdef CAPTURE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_P2) && (w_state_next == S_P2)) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_timeout_hit = (r_state == S_P2) && (r_to_cnt == C_TO_LAST);
`else
  logic [31:0] w_timeout_unused;
  assign w_timeout_unused = 32'(TIMEOUT_CYCLES);
  assign w_timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_P1;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A legal P2 commit wins over a timeout landing on the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_latch_p1   = 1'b0;
    w_latch_p2   = 1'b0;
    w_invalid    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_P1: begin
        if (w_commit) begin
          if (w_legal) begin
            w_latch_p1   = 1'b1;
            w_state_next = S_P2;
          end else begin
            w_invalid = 1'b1;
          end
        end
      end
      S_P2: begin
        if (w_commit && w_legal) begin
          w_latch_p2   = 1'b1;
          w_state_next = S_OUT;
        end else begin
          w_invalid = w_commit;
          if (w_timeout_hit) begin
            w_timeout    = 1'b1;
            w_state_next = S_P1;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          w_state_next = S_P1;
        end
      end
      default: begin
        w_state_next = S_P1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p1      <= 3'b000;
      r_p2      <= 3'b000;
      r_invalid <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_invalid <= w_invalid;
      r_timeout <= w_timeout;
      if (w_latch_p1) begin
        r_p1 <= sw_choice;
      end else if (w_timeout) begin
        r_p1 <= 3'b000;
      end
      if (w_latch_p2) begin
        r_p2 <= sw_choice;
      end
    end
  end

  assign out_valid     = (r_state == S_OUT);
  assign p1_choice     = r_p1;
  assign p2_choice     = r_p2;
  assign invalid_pulse = r_invalid;
  assign timeout_pulse = r_timeout;
  assign waiting_p1    = reset | (r_state == S_P1);
  assign waiting_p2    = ~reset & (r_state == S_P2);

endmodule

`default_nettype wire

// File: doc/choice_capture.md
CHOICE_CAPTURE -- requirements
Module: choice_capture

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable cycles needed to accept a key level change (10 ms at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 500000000, is the maximum number of cycles spent waiting for player 2 (10 s); it is used only when CAPTURE_TIMEOUT_EN is defined.
REQ-003 Port clk, input, 1 bit: the single clock. The design is one clock domain, and all state updates on the rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port sw_choice, input, 3 bits: the shared choice switches. Legal values are CAT=001, DOG=010 and CHICKEN=100.
REQ-006 Port key_commit_n, input, 1 bit: raw, asynchronous, active-low commit pushbutton.
REQ-007 Port out_ready, input, 1 bit: the downstream scenario stage accepts the pair.
REQ-008 Port out_valid, output, 1 bit: the captured pair is available.
REQ-009 Port p1_choice, output, 3 bits: player 1's one-hot choice.
REQ-010 Port p2_choice, output, 3 bits: player 2's one-hot choice.
REQ-011 Port waiting_p1, output, 1 bit: the block is in state S_P1.
REQ-012 Port waiting_p2, output, 1 bit: the block is in state S_P2.
REQ-013 Port invalid_pulse, output, 1 bit: one-cycle pulse when a commit arrives with a non-one-hot sw_choice.
REQ-014 Port timeout_pulse, output, 1 bit: one-cycle pulse when the player-2 wait times out.

Function
REQ-015 key_commit_n shall pass through a 2-flop synchronizer before any other use.
REQ-016 Debounce:
- The debounced level shall change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Any bounce shall restart the count.
REQ-017 A commit event shall be a 1-to-0 transition of the debounced level, lasting exactly one cycle per press.
- Release shall generate no event.
- Holding the key shall generate no further events.
REQ-018 The FSM states shall be S_P1, S_P2 and S_OUT.
REQ-019 In S_P1, a commit with legal sw_choice shall:
- latch p1_choice;
- move to S_P2 on the next edge.
REQ-020 In S_P2, a commit with legal sw_choice shall:
- latch p2_choice;
- move to S_OUT on the next edge.
REQ-021 In S_P1 or S_P2, a commit with illegal sw_choice (zero or multi-hot) shall:
- assert invalid_pulse for one cycle;
- leave state and latched choices unchanged.
REQ-022 In S_OUT, out_valid shall be 1, and p1_choice and p2_choice shall be held stable until out_valid && out_ready.
REQ-023 On out_valid && out_ready, the FSM shall return to S_P1 on the next edge, and out_valid shall drop that edge.
REQ-024 Commits arriving in S_OUT shall be ignored, with no pulse output.
REQ-025 out_valid shall be 1 exactly when the state is S_OUT, asserting on the cycle after the accepting P2 commit.
REQ-026 A commit and out_ready arriving in the same S_OUT cycle shall complete the handshake and discard the commit.
REQ-027 out_ready shall have no effect outside S_OUT.
REQ-028 End-to-end latency from a stable raw press to the state change shall be 2 + DEBOUNCE_CYCLES + 1 cycles.

Reset
REQ-029 When reset=1 at a clock edge, the block shall enter S_P1 and clear all of the following:
- p1_choice and p2_choice to 000;
- out_valid, invalid_pulse and timeout_pulse to 0;
- the debounce and timeout counters to 0.
REQ-030 On reset, the synchronizer and debounced level shall be set to 1 (released), so that a key held during reset produces no commit.
REQ-031 Reset in any state, including mid-handshake in S_OUT, shall take effect at the next edge and discard any partial round.
REQ-032 During reset, waiting_p1 shall read 1 and waiting_p2 shall read 0.

Configuration
REQ-033 The macro CAPTURE_TIMEOUT_EN shall control the player-2 timeout.
REQ-034 When CAPTURE_TIMEOUT_EN is defined:
- a counter shall run while in S_P2 and clear on leaving S_P2;
- when it reaches TIMEOUT_CYCLES-1 without a legal commit, the block shall pulse timeout_pulse for one cycle, clear p1_choice and return to S_P1.
REQ-035 A legal commit arriving on the timeout cycle shall take priority over the timeout, with no timeout_pulse.
REQ-036 When CAPTURE_TIMEOUT_EN is undefined, timeout_pulse shall be tied to 0, S_P2 shall wait indefinitely, and no counter shall be synthesized.

Structure
REQ-037 Shared package game_pkg shall hold:
- the CAT, DOG and CHICKEN 3-bit one-hot constants;
- the state enum for this FSM;
- a one-hot legality function.
REQ-038 A sub-module key_debounce shall contain the synchronizer, debounce counter and falling-edge detector, parameterized by DEBOUNCE_CYCLES.
- It outputs a one-cycle commit pulse.
REQ-039 The FSM, choice registers and timeout counter shall live in choice_capture.

Verification
REQ-040 The bench shall cover the following directed scenarios, with DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=50:
- Clean round: sw=001 press, then sw=100 press, with out_ready=1 → out_valid for 1 cycle, p1=001, p2=100, then back to S_P1.
- Bounce: toggle key every 2 cycles for 20 cycles, then hold low → exactly one commit, 7 cycles after the stable low.
- Illegal choice: sw=011 press in S_P1 → invalid_pulse=1 for 1 cycle, waiting_p1 stays 1, p1 unchanged.
- Backpressure: complete a round with out_ready=0 for 30 cycles while pressing again → out_valid held, data stable, extra press ignored; accepted when out_ready=1.
- Reset mid-S_OUT: assert reset for 1 cycle → out_valid=0, p1=p2=000, waiting_p1=1 on the next cycle.
- With CAPTURE_TIMEOUT_EN defined, P1 commit then no press for 50 cycles → timeout_pulse for 1 cycle, p1=000, state S_P1.
